// File: rtl/register_file_onehot.sv
// register_file_onehot
// Sixteen-entry register file written through a one-hot select that comes
// straight from the write-address decoder. It has two combinational read
// ports. Any write whose select has more than one bit set is rejected, and
// the rejection is recorded in a sticky error flag. A wrapping counter
// tracks how many writes were committed.
//
// Optional feature, selected by the macro REGFILE_WR_BYPASS_EN:
//   defined   - a legal one-hot write is forwarded to any read port that
//               addresses the same register in the same cycle.
//   undefined - read ports always show stored contents; a write becomes
//               visible on the cycle after its edge.
//
// No handshake: a write is offered with we=1 and commits at the next
// rising edge if wsel is exactly one-hot. Reads never stall.
module register_file_onehot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [15:0]      wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       raddr1,
    input  logic [3:0]       raddr2,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             onehot_err,
    output logic [7:0]       wr_count
);

    localparam int NREGS = 16;

    logic [WIDTH-1:0] regs [NREGS];

    // Select classification. A nonzero word with only one bit set stays
    // nonzero after clearing its lowest set bit only if more bits were set.
    logic        sel_any;
    logic        sel_single;
    logic        sel_multi;
    logic        wr_commit;
    logic        wr_reject;
    logic [15:0] sel_low_cleared;

    // Classify the select word and qualify it with the global write enable.
    always_comb begin
        sel_low_cleared = wsel & (wsel - 16'd1);
        sel_any         = (wsel != 16'd0);
        sel_single      = sel_any && (sel_low_cleared == 16'd0);
        sel_multi       = sel_any && (sel_low_cleared != 16'd0);
        wr_commit       = we && sel_single;
        wr_reject       = we && sel_multi;
    end

    // Storage. Each entry loads only on a committed write that selects it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Sticky reject flag. A new reject at the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            onehot_err <= 1'b0;
        end else if (wr_reject) begin
            onehot_err <= 1'b1;
        end else if (err_clr) begin
            onehot_err <= 1'b0;
        end
    end

    // Committed-write counter, wraps modulo 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= 8'd0;
        end else if (wr_commit) begin
            wr_count <= wr_count + 8'd1;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    // Encoded write index. It is only meaningful when the select is
    // exactly one-hot, and it is only used under that condition.
    logic [3:0] wr_index;
    logic       fwd1;
    logic       fwd2;

    // Convert the one-hot select into a register index for forwarding.
    always_comb begin
        wr_index = 4'd0;
        for (int i = 0; i < NREGS; i++) begin
            if (wsel[i]) begin
                wr_index = 4'(i);
            end
        end
    end

    // Forward only legal writes, and never while reset holds the file at zero.
    always_comb begin
        fwd1 = wr_commit && !reset && (raddr1 == wr_index);
        fwd2 = wr_commit && !reset && (raddr2 == wr_index);
    end

    // Read ports, preferring in-flight write data when it targets the same entry.
    always_comb begin
        rdata1 = fwd1 ? wdata : regs[raddr1];
        rdata2 = fwd2 ? wdata : regs[raddr2];
    end
`else
    // Read ports show stored contents only.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end
`endif

endmodule
